pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/riscv_pipe_pkg.sv | 17 +
 rtl/fwd_select.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Holds the FSM state enum, operand-forwarding codes and MUL_LAT bounds.
package riscv_pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int MUL_LAT_MIN = 1;
    localparam int MUL_LAT_MAX = 16;

endpackage

// File: rtl/fwd_select.sv
// Single-operand forwarding mux select: MEM beats WB, x0 never forwards.
// WB forwarding exists only when PIPE_FWD_WB_EN is defined.
module fwd_select
    import riscv_pipe_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] rs_addr_e,
    input  logic [ADDR_W-1:0] rd_addr_m,
    input  logic              rd_wen_m,
    input  logic [ADDR_W-1:0] rd_addr_w,
    input  logic              rd_wen_w,
    output logic [1:0]        fwd_sel
);

`ifdef PIPE_FWD_WB_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = rd_wen_m && (rd_addr_m != '0)
                     && (rd_addr_m == rs_addr_e);
    // Without WB forwarding the regfile write-through covers that distance.
    assign wb_hit  = WB_EN && rd_wen_w && (rd_addr_w != '0)
                     && (rd_addr_w == rs_addr_e);

    always_comb begin
        fwd_sel = FWD_RF;
        unique case (1'b1)
            mem_hit:             fwd_sel = FWD_MEM;
            (!mem_hit && wb_hit): fwd_sel = FWD_WB;
            default:             fwd_sel = FWD_RF;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: load-use stall, multi-cycle multiply, redirect, forwarding.
// Define PIPE_FWD_WB_EN to enable writeback-stage forwarding (fwd_sel = 10).
module pipe_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1_addr_d,
    input  logic [ADDR_W-1:0] rs2_addr_d,
    input  logic [ADDR_W-1:0] rs1_addr_e,
    input  logic [ADDR_W-1:0] rs2_addr_e,
    input  logic [ADDR_W-1:0] rd_addr_e,
    input  logic              rd_wen_e,
    input  logic              dmem_read_en_e,
    input  logic              mul_en_e,
    input  logic [ADDR_W-1:0] rd_addr_m,
    input  logic              rd_wen_m,
    input  logic [ADDR_W-1:0] rd_addr_w,
    input  logic              rd_wen_w,
    input  logic              pc_branch_en_sel,
    output logic              stall_fd,
    output logic              stall_de,
    output logic              bubble_de,
    output logic              bubble_em,
    output logic              flush_fd,
    output logic              flush_de,
    output logic [1:0]        fwd_sel1_e,
    output logic [1:0]        fwd_sel2_e,
    output logic              mul_busy
);

    localparam int CNT_W = $clog2(MUL_LAT) + 1;
    localparam bit MUL_MULTI = (MUL_LAT >= 2);
    localparam logic [CNT_W-1:0] CNT_INIT =
        MUL_MULTI ? CNT_W'(MUL_LAT - 2) : '0;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] mul_cnt_q;
    logic [CNT_W-1:0] mul_cnt_d;

    logic mul_start;
    logic mul_hold;
    logic load_use;
    logic live;
    logic [1:0] sel1;
    logic [1:0] sel2;

    // The release cycle (count at zero) never re-arms, even with mul_en_e high.
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        mul_start = 1'b0;
        mul_hold  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mul_en_e && MUL_MULTI) begin
                    mul_start = 1'b1;
                    state_d   = MUL_BUSY;
                    mul_cnt_d = CNT_INIT;
                end
            end
            MUL_BUSY: begin
                if (mul_cnt_q != '0) begin
                    mul_hold  = 1'b1;
                    mul_cnt_d = mul_cnt_q - CNT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    assign load_use = (state_q == RUN) && dmem_read_en_e && rd_wen_e
                      && (rd_addr_e != '0)
                      && ((rd_addr_e == rs1_addr_d)
                          || (rd_addr_e == rs2_addr_d));

    assign live = !reset;

    // Redirect squashes the younger stages, so a load-use stall is moot.
    assign flush_fd  = live && pc_branch_en_sel;
    assign flush_de  = live && pc_branch_en_sel;
    assign bubble_de = live && load_use && !pc_branch_en_sel;
    assign stall_fd  = live && ((load_use && !pc_branch_en_sel)
                                || mul_start || mul_hold);
    assign stall_de  = live && (mul_start || mul_hold);
    assign bubble_em = live && (mul_start || mul_hold);
    assign mul_busy  = live && (state_q == MUL_BUSY);

    fwd_select #(.ADDR_W(ADDR_W)) u_fwd1 (
        .rs_addr_e (rs1_addr_e),
        .rd_addr_m (rd_addr_m),
        .rd_wen_m  (rd_wen_m),
        .rd_addr_w (rd_addr_w),
        .rd_wen_w  (rd_wen_w),
        .fwd_sel   (sel1)
    );

    fwd_select #(.ADDR_W(ADDR_W)) u_fwd2 (
        .rs_addr_e (rs2_addr_e),
        .rd_addr_m (rd_addr_m),
        .rd_wen_m  (rd_wen_m),
        .rd_addr_w (rd_addr_w),
        .rd_wen_w  (rd_wen_w),
        .fwd_sel   (sel2)
    );

    assign fwd_sel1_e = live ? sel1 : FWD_RF;
    assign fwd_sel2_e = live ? sel2 : FWD_RF;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MUL_LAT = 3, 1 and 8 instances.
// Expected WB forwarding value follows PIPE_FWD_WB_EN.
module tb_pipe_hazard_ctrl;
    import riscv_pipe_pkg::*;

`ifdef PIPE_FWD_WB_EN
    localparam logic [1:0] WB_EXP = FWD_WB;
`else
    localparam logic [1:0] WB_EXP = FWD_RF;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, reset8, mul_en8;
    logic [4:0] rs1_addr_d, rs2_addr_d, rs1_addr_e, rs2_addr_e;
    logic [4:0] rd_addr_e, rd_addr_m, rd_addr_w;
    logic       rd_wen_e, dmem_read_en_e, mul_en_e;
    logic       rd_wen_m, rd_wen_w, pc_branch_en_sel;

    logic       a_stall_fd, a_stall_de, a_bubble_de, a_bubble_em;
    logic       a_flush_fd, a_flush_de, a_mul_busy;
    logic [1:0] a_fwd1, a_fwd2;
    logic       b_stall_fd, b_stall_de, b_bubble_de, b_bubble_em;
    logic       b_flush_fd, b_flush_de, b_mul_busy;
    logic [1:0] b_fwd1, b_fwd2;
    logic       c_stall_fd, c_stall_de, c_bubble_de, c_bubble_em;
    logic       c_flush_fd, c_flush_de, c_mul_busy;
    logic [1:0] c_fwd1, c_fwd2;

    int n_cmp = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(.ADDR_W(5), .MUL_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .rs1_addr_d(rs1_addr_d), .rs2_addr_d(rs2_addr_d),
        .rs1_addr_e(rs1_addr_e), .rs2_addr_e(rs2_addr_e),
        .rd_addr_e(rd_addr_e), .rd_wen_e(rd_wen_e),
        .dmem_read_en_e(dmem_read_en_e), .mul_en_e(mul_en_e),
        .rd_addr_m(rd_addr_m), .rd_wen_m(rd_wen_m),
        .rd_addr_w(rd_addr_w), .rd_wen_w(rd_wen_w),
        .pc_branch_en_sel(pc_branch_en_sel),
        .stall_fd(a_stall_fd), .stall_de(a_stall_de),
        .bubble_de(a_bubble_de), .bubble_em(a_bubble_em),
        .flush_fd(a_flush_fd), .flush_de(a_flush_de),
        .fwd_sel1_e(a_fwd1), .fwd_sel2_e(a_fwd2),
        .mul_busy(a_mul_busy)
    );

    pipe_hazard_ctrl #(.ADDR_W(5), .MUL_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .rs1_addr_d(rs1_addr_d), .rs2_addr_d(rs2_addr_d),
        .rs1_addr_e(rs1_addr_e), .rs2_addr_e(rs2_addr_e),
        .rd_addr_e(rd_addr_e), .rd_wen_e(rd_wen_e),
        .dmem_read_en_e(dmem_read_en_e), .mul_en_e(mul_en_e),
        .rd_addr_m(rd_addr_m), .rd_wen_m(rd_wen_m),
        .rd_addr_w(rd_addr_w), .rd_wen_w(rd_wen_w),
        .pc_branch_en_sel(pc_branch_en_sel),
        .stall_fd(b_stall_fd), .stall_de(b_stall_de),
        .bubble_de(b_bubble_de), .bubble_em(b_bubble_em),
        .flush_fd(b_flush_fd), .flush_de(b_flush_de),
        .fwd_sel1_e(b_fwd1), .fwd_sel2_e(b_fwd2),
        .mul_busy(b_mul_busy)
    );

    pipe_hazard_ctrl #(.ADDR_W(5), .MUL_LAT(8)) dut8 (
        .clk(clk), .reset(reset8),
        .rs1_addr_d(rs1_addr_d), .rs2_addr_d(rs2_addr_d),
        .rs1_addr_e(rs1_addr_e), .rs2_addr_e(rs2_addr_e),
        .rd_addr_e(rd_addr_e), .rd_wen_e(rd_wen_e),
        .dmem_read_en_e(dmem_read_en_e), .mul_en_e(mul_en8),
        .rd_addr_m(rd_addr_m), .rd_wen_m(rd_wen_m),
        .rd_addr_w(rd_addr_w), .rd_wen_w(rd_wen_w),
        .pc_branch_en_sel(pc_branch_en_sel),
        .stall_fd(c_stall_fd), .stall_de(c_stall_de),
        .bubble_de(c_bubble_de), .bubble_em(c_bubble_em),
        .flush_fd(c_flush_fd), .flush_de(c_flush_de),
        .fwd_sel1_e(c_fwd1), .fwd_sel2_e(c_fwd2),
        .mul_busy(c_mul_busy)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        rs1_addr_d = '0; rs2_addr_d = '0;
        rs1_addr_e = '0; rs2_addr_e = '0;
        rd_addr_e = '0; rd_wen_e = 1'b0;
        dmem_read_en_e = 1'b0; mul_en_e = 1'b0;
        rd_addr_m = '0; rd_wen_m = 1'b0;
        rd_addr_w = '0; rd_wen_w = 1'b0;
        pc_branch_en_sel = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        clear_in();
        reset = 1'b1; reset8 = 1'b1; mul_en8 = 1'b0;
        // Drive every hazard during reset: outputs must stay 0.
        pc_branch_en_sel = 1'b1; mul_en_e = 1'b1;
        dmem_read_en_e = 1'b1; rd_wen_e = 1'b1;
        rd_addr_e = 5'd5; rs1_addr_d = 5'd5;
        rd_addr_m = 5'd7; rd_wen_m = 1'b1; rs1_addr_e = 5'd7;
        #1;
        chk("rst_stall_fd", 32'(a_stall_fd), 0);
        chk("rst_stall_de", 32'(a_stall_de), 0);
        chk("rst_bubble_de", 32'(a_bubble_de), 0);
        chk("rst_flush_fd", 32'(a_flush_fd), 0);
        chk("rst_fwd1", 32'(a_fwd1), 0);
        chk("rst_mul_busy", 32'(a_mul_busy), 0);
        tick();
        tick();
        reset = 1'b0;
        clear_in();

        // Load x5 in EX, decode reads x5 on rs2.
        dmem_read_en_e = 1'b1; rd_wen_e = 1'b1; rd_addr_e = 5'd5;
        rs1_addr_d = 5'd3; rs2_addr_d = 5'd5;
        #1;
        chk("lu_stall_fd", 32'(a_stall_fd), 1);
        chk("lu_bubble_de", 32'(a_bubble_de), 1);
        chk("lu_stall_de", 32'(a_stall_de), 0);
        chk("lu_bubble_em", 32'(a_bubble_em), 0);
        chk("lu_flush_fd", 32'(a_flush_fd), 0);
        tick();
        dmem_read_en_e = 1'b0; rd_wen_e = 1'b0; rd_addr_e = '0;
        #1;
        chk("lu_next_stall_fd", 32'(a_stall_fd), 0);
        chk("lu_next_bubble_de", 32'(a_bubble_de), 0);
        tick();

        // Load to x0 never stalls.
        dmem_read_en_e = 1'b1; rd_wen_e = 1'b1; rd_addr_e = 5'd0;
        rs1_addr_d = 5'd0; rs2_addr_d = 5'd0;
        #1;
        chk("lu_x0_stall_fd", 32'(a_stall_fd), 0);
        // Non-matching load destination.
        rd_addr_e = 5'd9; rs1_addr_d = 5'd8; rs2_addr_d = 5'd10;
        #1;
        chk("lu_nomatch_stall_fd", 32'(a_stall_fd), 0);
        // Match on rs1 with branch redirect: flush wins.
        rs1_addr_d = 5'd9; pc_branch_en_sel = 1'b1;
        #1;
        chk("pri_flush_fd", 32'(a_flush_fd), 1);
        chk("pri_flush_de", 32'(a_flush_de), 1);
        chk("pri_stall_fd", 32'(a_stall_fd), 0);
        chk("pri_bubble_de", 32'(a_bubble_de), 0);
        tick();
        clear_in();

        // Forwarding.
        rd_addr_m = 5'd7; rd_wen_m = 1'b1;
        rd_addr_w = 5'd7; rd_wen_w = 1'b1;
        rs1_addr_e = 5'd7; rs2_addr_e = 5'd3;
        #1;
        chk("fwd_mem_pri", 32'(a_fwd1), 32'(FWD_MEM));
        chk("fwd_op2_none", 32'(a_fwd2), 32'(FWD_RF));
        rd_addr_m = 5'd0;
        #1;
        chk("fwd_wb", 32'(a_fwd1), 32'(WB_EXP));
        rs2_addr_e = 5'd9; rd_addr_m = 5'd9; rd_wen_m = 1'b0;
        rd_addr_w = 5'd9;
        #1;
        chk("fwd_wen_m_off", 32'(a_fwd2), 32'(WB_EXP));
        rd_wen_m = 1'b1;
        #1;
        chk("fwd_op2_mem", 32'(a_fwd2), 32'(FWD_MEM));
        rs1_addr_e = 5'd0; rd_addr_m = 5'd0; rd_addr_w = 5'd0;
        #1;
        chk("fwd_x0", 32'(a_fwd1), 32'(FWD_RF));
        tick();
        clear_in();

        // Multiply, held in EX for MUL_LAT cycles.
        mul_en_e = 1'b1;
        #1;
        chk("mul_c0_stall_fd", 32'(a_stall_fd), 1);
        chk("mul_c0_stall_de", 32'(a_stall_de), 1);
        chk("mul_c0_bubble_em", 32'(a_bubble_em), 1);
        chk("mul_c0_busy", 32'(a_mul_busy), 0);
        chk("mul1_c0_stall_fd", 32'(b_stall_fd), 0);
        tick();
        rd_addr_m = 5'd4; rd_wen_m = 1'b1; rs1_addr_e = 5'd4;
        #1;
        chk("mul_c1_stall_fd", 32'(a_stall_fd), 1);
        chk("mul_c1_bubble_em", 32'(a_bubble_em), 1);
        chk("mul_c1_busy", 32'(a_mul_busy), 1);
        chk("mul_c1_fwd1", 32'(a_fwd1), 32'(FWD_MEM));
        chk("mul1_c1_busy", 32'(b_mul_busy), 0);
        chk("mul1_c1_stall_de", 32'(b_stall_de), 0);
        tick();
        #1;
        chk("mul_c2_stall_fd", 32'(a_stall_fd), 0);
        chk("mul_c2_stall_de", 32'(a_stall_de), 0);
        chk("mul_c2_busy", 32'(a_mul_busy), 1);
        tick();
        mul_en_e = 1'b0;
        #1;
        chk("mul_c3_busy", 32'(a_mul_busy), 0);
        chk("mul_c3_stall_fd", 32'(a_stall_fd), 0);
        tick();
        clear_in();

        // MUL_LAT=8 reset in the second MUL_BUSY cycle.
        reset8 = 1'b0; mul_en8 = 1'b1;
        #1;
        chk("m8_c0_stall_fd", 32'(c_stall_fd), 1);
        tick();
        #1;
        chk("m8_c1_busy", 32'(c_mul_busy), 1);
        tick();
        reset8 = 1'b1; pc_branch_en_sel = 1'b1;
        #1;
        chk("m8_rst_busy", 32'(c_mul_busy), 0);
        chk("m8_rst_stall_fd", 32'(c_stall_fd), 0);
        chk("m8_rst_bubble_em", 32'(c_bubble_em), 0);
        chk("m8_rst_flush_de", 32'(c_flush_de), 0);
        tick();
        reset8 = 1'b0; mul_en8 = 1'b0; pc_branch_en_sel = 1'b0;
        #1;
        chk("m8_post_busy", 32'(c_mul_busy), 0);
        chk("m8_post_stall_fd", 32'(c_stall_fd), 0);
        chk("m8_post_stall_de", 32'(c_stall_de), 0);
        tick();
        #1;
        chk("m8_post2_busy", 32'(c_mul_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
